dcache_miss_sequencer: RTL and testbench

//  Sequences the 2-way, 16-set, 256-bit-line data-cache SRAM for a single CPU load/store port.

---
 rtl/dcache_miss_sequencer_if.sv | 47 ++++
 rtl/dcache_miss_sequencer.sv | 140 ++++++++++++++
 tb/tb_dcache_miss_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_sequencer_if.sv
// Signal bundle between the dcache miss sequencer and its CPU, SRAM and memory neighbours.
// The master modport is the sequencer; the slave modport is the surrounding system.
interface dcache_miss_sequencer_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;

  logic [3:0]   sram_idx_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;

  // Memory handshake: mem_req_o is held high with mem_write_o/mem_addr_o/mem_data_o
  // stable until mem_ack_i is sampled high on a clock edge; the ack is a one-cycle
  // pulse, mem_data_i is valid with it, and req drops on the edge that takes the ack.
  logic         mem_req_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_idx_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_req_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_idx_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_req_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_miss_sequencer.sv
// Miss sequencer for a 2-way, 16-set, 256-bit-line data cache: hits finish in IDLE,
// misses stall the CPU through optional write-back, fill, install and a re-lookup.
module dcache_miss_sequencer #(
  parameter int TAG_W = 23,
  parameter int IDX_W = 4,
  parameter int OFS_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_miss_sequencer_if.master bus,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [CNT_W-1:0]     miss_cnt_o,
  output logic [2:0]           dbg_state_o
);
  localparam int TAG_LSB = OFS_W + IDX_W;
  localparam int LINE_W  = 8 << OFS_W;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_INSTALL, S_RETRY} state_t;

  state_t              r_state, w_state_next;
  logic                r_mem_req, r_mem_write;
  logic [31:2]         r_addr;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic [TAG_W-1:0]    r_victim_tag;
  logic [LINE_W-1:0]   r_victim_data;
  logic [LINE_W-1:0]   r_line;
  logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

  logic [31:2]         w_addr;
  logic                w_write;
  logic [31:0]         w_wdata;
  logic [OFS_W-3:0]    w_word_sel;
  logic [LINE_W-1:0]   w_merged;
  logic                w_ack;
  logic                w_miss;

  // Once a miss is taken the CPU inputs are ignored; the latched copy drives RETRY.
  assign w_addr     = (r_state == S_IDLE) ? bus.cpu_addr_i[31:2] : r_addr;
  assign w_write    = (r_state == S_IDLE) ? bus.cpu_write_i : r_write;
  assign w_wdata    = (r_state == S_IDLE) ? bus.cpu_data_i : r_wdata;
  assign w_word_sel = w_addr[OFS_W-1:2];
  assign w_ack      = r_mem_req & bus.mem_ack_i;
  assign w_miss     = (r_state == S_IDLE) & bus.cpu_req_i & ~bus.sram_hit_i;

  assign bus.sram_idx_o  = w_addr[TAG_LSB-1:OFS_W];
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_write_o = r_mem_write;
  assign bus.mem_data_o  = r_victim_data;
  assign hit_cnt_o       = r_hit_cnt;
  assign miss_cnt_o      = r_miss_cnt;
  assign dbg_state_o     = r_state;

  always_comb begin
    w_merged = bus.sram_data_i;
    w_merged[{w_word_sel, 5'b0} +: 32] = w_wdata;
  end

  always_comb begin
    w_state_next      = r_state;
    bus.cpu_stall_o   = 1'b1;
    bus.cpu_data_o    = '0;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    bus.mem_addr_o    = '0;
    case (r_state)
      S_IDLE: begin
        bus.cpu_stall_o   = bus.cpu_req_i & ~bus.sram_hit_i;
        bus.sram_enable_o = bus.cpu_req_i;
        bus.sram_write_o  = bus.cpu_req_i & bus.cpu_write_i & bus.sram_hit_i;
        bus.cpu_data_o    = bus.sram_data_i[{w_word_sel, 5'b0} +: 32];
        bus.sram_tag_o    = {2'b11, w_addr[31:TAG_LSB]};
        bus.sram_data_o   = w_merged;
        if (w_miss)
          w_state_next = (bus.sram_tag_i[TAG_W+1] & bus.sram_tag_i[TAG_W]) ? S_WB : S_FILL;
      end
      S_WB: begin
        bus.mem_addr_o = {r_victim_tag, r_addr[TAG_LSB-1:OFS_W], {OFS_W{1'b0}}};
        if (w_ack) w_state_next = S_FILL;
      end
      S_FILL: begin
        bus.mem_addr_o = {r_addr[31:OFS_W], {OFS_W{1'b0}}};
        if (w_ack) w_state_next = S_INSTALL;
      end
      S_INSTALL: begin
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = 1'b1;
        bus.sram_tag_o    = {2'b10, r_addr[31:TAG_LSB]};
        bus.sram_data_o   = r_line;
        w_state_next      = S_RETRY;
      end
      S_RETRY: begin
        bus.cpu_stall_o   = 1'b0;
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = w_write & bus.sram_hit_i;
        bus.cpu_data_o    = bus.sram_data_i[{w_word_sel, 5'b0} +: 32];
        bus.sram_tag_o    = {2'b11, w_addr[31:TAG_LSB]};
        bus.sram_data_o   = w_merged;
        w_state_next      = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_victim_tag  <= '0;
      r_victim_data <= '0;
      r_line        <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      // Request is registered, so it rises one cycle after entering WB/FILL.
      r_mem_req   <= ((r_state == S_WB) || (r_state == S_FILL)) && !w_ack;
      r_mem_write <= (r_state == S_WB) && !w_ack;
      if (w_miss) begin
        r_addr        <= bus.cpu_addr_i[31:2];
        r_write       <= bus.cpu_write_i;
        r_wdata       <= bus.cpu_data_i;
        r_victim_tag  <= bus.sram_tag_i[TAG_W-1:0];
        r_victim_data <= bus.sram_data_i;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if ((r_state == S_IDLE) && bus.cpu_req_i && bus.sram_hit_i && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if ((r_state == S_FILL) && w_ack)
        r_line <= bus.mem_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_miss_sequencer.sv
// Bench for dcache_miss_sequencer: behavioural SRAM and memory around the DUT, and a
// reference model of memory contents plus per-set LRU residency predicting every access.
`timescale 1ns/1ps
module tb_dcache_miss_sequencer;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_miss_sequencer_if bus();
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic [2:0]       dbg_state;

  dcache_miss_sequencer #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  ref_mem[logic [31:0]];   // architectural words written by stores
  logic [31:0]  res_q[$];                // resident line addresses, most recent first
  bit           dirty[logic [31:0]];
  logic [32:0]  exp_q[$];                // expected memory ops {write, line addr}
  logic [255:0] bmem[logic [31:0]];      // backing memory lines written back
  int           exp_hit = 0;
  int           exp_miss = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = ref_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  task automatic predict(input logic wr, input logic [31:0] addr, output bit hit);
    logic [31:0] line, e;
    int pos, cnt, last;
    line = {addr[31:5], 5'b0};
    pos = -1; cnt = 0; last = -1;
    for (int i = 0; i < res_q.size(); i++) begin
      e = res_q[i];
      if (e == line) pos = i;
      if (e[8:5] == line[8:5]) begin cnt++; last = i; end
    end
    hit = (pos >= 0);
    if (hit) begin
      res_q.delete(pos);
    end else begin
      if (cnt == 2) begin
        e = res_q[last];
        if (dirty.exists(e)) exp_q.push_back({1'b1, e});
        dirty.delete(e);
        res_q.delete(last);
      end
      exp_q.push_back({1'b0, line});
    end
    res_q.push_front(line);
    if (wr) dirty[line] = 1'b1;
  endtask

  // ---------------- SRAM model ----------------
  logic [22:0]  sv_tag [16][2];
  logic         sv_v   [16][2];
  logic         sv_d   [16][2];
  logic [255:0] sv_data[16][2];
  logic         sv_lru [16];
  logic         s_hit, s_way, env_clr;

  always_comb begin
    s_hit = 1'b0;
    s_way = sv_lru[bus.sram_idx_o];
    for (int w = 0; w < 2; w++)
      if (sv_v[bus.sram_idx_o][w] && sv_tag[bus.sram_idx_o][w] == bus.cpu_addr_i[31:9]) begin
        s_hit = 1'b1;
        s_way = w[0];
      end
    bus.sram_hit_i  = s_hit;
    bus.sram_tag_i  = {sv_v[bus.sram_idx_o][s_way], sv_d[bus.sram_idx_o][s_way], sv_tag[bus.sram_idx_o][s_way]};
    bus.sram_data_i = sv_data[bus.sram_idx_o][s_way];
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int s = 0; s < 16; s++) begin
        sv_lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          sv_v[s][w] <= 1'b0; sv_d[s][w] <= 1'b0; sv_tag[s][w] <= '0; sv_data[s][w] <= '0;
        end
      end
    end else if (bus.sram_enable_o) begin
      if (s_hit) sv_lru[bus.sram_idx_o] <= ~s_way;
      if (bus.sram_write_o) begin
        sv_v[bus.sram_idx_o][s_way]    <= bus.sram_tag_o[24];
        sv_d[bus.sram_idx_o][s_way]    <= bus.sram_tag_o[23];
        sv_tag[bus.sram_idx_o][s_way]  <= bus.sram_tag_o[22:0];
        sv_data[bus.sram_idx_o][s_way] <= bus.sram_data_o;
      end
    end
  end

  // ---------------- memory responder ----------------
  bit ack_hold = 1'b0;
  int ack_fix  = 3;
  int dly      = 3;

  task automatic serve();
    logic [32:0] e;
    check("mem_op_expected", 256'(exp_q.size() > 0), 256'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_op", {bus.mem_write_o, bus.mem_addr_o}, e);
    end
    if (bus.mem_write_o) begin
      check("wb_data", bus.mem_data_o, ref_line(bus.mem_addr_o));
      bmem[bus.mem_addr_o] = bus.mem_data_o;
    end else begin
      bus.mem_data_i = mem_line(bus.mem_addr_o);
    end
  endtask

  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        dly = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
      end else if (bus.mem_req_o && !ack_hold) begin
        if (dly > 0) dly--;
        else begin
          serve();
          bus.mem_ack_i = 1'b1;
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit hit, done;
    int cyc;
    logic [2:0] ws;
    ws = addr[4:2];
    predict(wr, addr, hit);
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = wr; bus.cpu_addr_i = addr; bus.cpu_data_i = data;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) check("first_stall", bus.cpu_stall_o, !hit);
      if (!bus.cpu_stall_o) begin
        done = 1'b1;
        if (wr) begin
          check("st_we", bus.sram_write_o, 1'b1);
          check("st_tag", bus.sram_tag_o, {2'b11, addr[31:9]});
          check("st_word", bus.sram_data_o[{ws, 5'b0} +: 32], data);
        end else begin
          check("ld_data", bus.cpu_data_o, ref_word(addr));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("access_done", done, 1'b1);
    bus.cpu_req_i = 1'b0;
    if (wr) ref_mem[addr] = data;
    if (hit) exp_hit = (exp_hit < 65535) ? exp_hit + 1 : 65535;
    else     exp_miss = (exp_miss < 65535) ? exp_miss + 1 : 65535;
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
    check("mem_ops_drained", exp_q.size(), 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_stall", bus.cpu_stall_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    rst = 1'b1; env_clr = 1'b1;
    bus.cpu_req_i = 1'b0; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; env_clr = 1'b0;
    check("rst_state", dbg_state, 3'd0);
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_mem_write", bus.mem_write_o, 1'b0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    idle_cycle();

    // cold load, repeat hit, store then load in the same line
    do_access(1'b0, 32'h0000_0040, 32'h0);
    check("cold_miss_cnt", miss_cnt, 1);
    do_access(1'b0, 32'h0000_0040, 32'h0);
    check("repeat_hit_cnt", hit_cnt, 1);
    do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_0044, 32'h0);
    // fill second way of set 2, then a third tag evicts the dirty line
    ack_fix = -1;
    do_access(1'b0, 32'h0000_0240, 32'h0);
    do_access(1'b0, 32'h0000_0440, 32'h0);
    do_access(1'b0, 32'h0000_0044, 32'h0);
    check("wb_roundtrip", bus.cpu_addr_i, 32'h44);

    // reset while waiting for a fill of an untouched set
    ack_hold = 1'b1;
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h0000_01E0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_req", bus.mem_req_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_req_i = 1'b0;
    check("midrst_state", dbg_state, 3'd0);
    check("midrst_mem_req", bus.mem_req_o, 1'b0);
    check("midrst_hit_cnt", hit_cnt, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    exp_hit = 0; exp_miss = 0;
    dly = 0; ack_hold = 1'b0;
    idle_cycle();

    // randomized traffic over 4 tags x 4 sets
    for (int n = 0; n < 300; n++) begin
      a = {21'd0, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // drive the hit counter into saturation
    for (int n = 0; n < (1 << CNT_W) + 4; n++) do_access(1'b0, 32'h0000_0060, 32'h0);
    check("hit_sat", hit_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
